// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Requester identifiers (also the encoding of last_grant)
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Width of the memory latency counter (MEM_LATENCY up to 15)
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store requests.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties;
// otherwise the data port always wins over fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority never looks at grant history
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Choose a winner whenever at least one requester is asking
  always_comb begin
    gnt_valid = if_req | d_req;
    gnt_id    = REQ_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (if_req && d_req) begin
      // Tie: hand the port to whoever did not get it last time
      gnt_id = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
    end else if (d_req) begin
      gnt_id = REQ_D;
    end
`else
    if (d_req) begin
      gnt_id = REQ_D;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One access at a time: IDLE (arbitrate) -> ACCESS (hold address for
// MEM_LATENCY cycles) -> RESP (done pulse) -> IDLE.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              busy,
  output logic [ADDR_W-1:0] memory_addr,
  output logic [DATA_W-1:0] data_to_memory,
  output logic              write_to_memory,
  input  logic [DATA_W-1:0] data_from_memory,
  input  logic              memory_error
);

  state_t               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 gnt_q, gnt_d;
  logic                 last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
  logic                 if_err_q, if_err_d;
  logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;
  logic                 d_err_q, d_err_d;

  logic                 pick_valid;
  logic                 pick_id;
  logic                 access_last;
  logic [DATA_W-1:0]    capture_data;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .gnt_valid  (pick_valid),
    .gnt_id     (pick_id)
  );

  assign access_last  = (state_q == ACCESS) && (cnt_q == '0);
  // Stores and errored reads return zero so stale bus data never leaks out
  assign capture_data = (memory_error || mem_we_q) ? '0 : data_from_memory;

  // State register and all datapath flops; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= REQ_IF;
      last_grant_q <= REQ_IF;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait out the latency, one RESP cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid)  state_d = ACCESS;
      ACCESS:  if (access_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the winner's request, count latency, capture response
  always_comb begin
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    if_rdata_d   = if_rdata_q;
    if_err_d     = if_err_q;
    d_rdata_d    = d_rdata_q;
    d_err_d      = d_err_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d = pick_id;
          cnt_d = LAT_CNT_W'(MEM_LATENCY - 1);
          if (pick_id == REQ_D) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we;
          end else begin
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_we_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end else begin
          // Write strobe is confined to ACCESS, so drop it as we leave
          mem_we_d = 1'b0;
          if (gnt_q == REQ_D) begin
            d_rdata_d = capture_data;
            d_err_d   = memory_error;
          end else begin
            if_rdata_d = capture_data;
            if_err_d   = memory_error;
          end
        end
      end
      RESP: begin
        mem_we_d     = 1'b0;
        last_grant_d = gnt_q;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state: single done pulse for the winner in RESP
  always_comb begin
    busy    = (state_q != IDLE);
    if_done = (state_q == RESP) && (gnt_q == REQ_IF);
    d_done  = (state_q == RESP) && (gnt_q == REQ_D);
  end

  assign memory_addr     = mem_addr_q;
  assign data_to_memory  = mem_wdata_q;
  assign write_to_memory = mem_we_q;
  assign if_rdata        = if_rdata_q;
  assign if_err          = if_err_q;
  assign d_rdata         = d_rdata_q;
  assign d_err           = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MEM_LATENCY = 2).
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        busy;
  logic [31:0] memory_addr;
  logic [31:0] data_to_memory;
  logic        write_to_memory;
  logic [31:0] data_from_memory;
  logic        memory_error;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_LATENCY (L)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_rdata         (if_rdata),
    .if_done          (if_done),
    .if_err           (if_err),
    .d_req            (d_req),
    .d_we             (d_we),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_rdata          (d_rdata),
    .d_done           (d_done),
    .d_err            (d_err),
    .busy             (busy),
    .memory_addr      (memory_addr),
    .data_to_memory   (data_to_memory),
    .write_to_memory  (write_to_memory),
    .data_from_memory (data_from_memory),
    .memory_error     (memory_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_if_done"},  {31'b0, if_done}, 32'h0);
    chk({tag, "_if_err"},   {31'b0, if_err}, 32'h0);
    chk({tag, "_d_rdata"},  d_rdata, 32'h0);
    chk({tag, "_d_done"},   {31'b0, d_done}, 32'h0);
    chk({tag, "_d_err"},    {31'b0, d_err}, 32'h0);
    chk({tag, "_busy"},     {31'b0, busy}, 32'h0);
    chk({tag, "_maddr"},    memory_addr, 32'h0);
    chk({tag, "_mwdata"},   data_to_memory, 32'h0);
    chk({tag, "_mwe"},      {31'b0, write_to_memory}, 32'h0);
  endtask

  // Called just after a rising edge with the arbiter in IDLE and requests set.
  // Walks ACCESS (L cycles), RESP, and the following IDLE cycle.
  task automatic run_access(input string tag, input logic exp_d,
                            input logic [31:0] exp_addr, input logic exp_we,
                            input logic [31:0] exp_wdata,
                            input logic [31:0] mem_data, input logic mem_err,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic drop_mid, input logic drop_at_done);
    @(posedge clk); #1;
    for (int i = 0; i < L; i++) begin
      chk({tag, "_acc_busy"}, {31'b0, busy}, 32'h1);
      chk({tag, "_acc_addr"}, memory_addr, exp_addr);
      chk({tag, "_acc_we"},   {31'b0, write_to_memory}, {31'b0, exp_we});
      if (exp_we) chk({tag, "_acc_wdata"}, data_to_memory, exp_wdata);
      chk({tag, "_acc_done"}, {30'b0, if_done, d_done}, 32'h0);
      if (drop_mid && i == 0) begin
        if_req  = 1'b0;
        d_req   = 1'b0;
        if_addr = 32'hFFFF_FFFF;
        d_addr  = 32'hFFFF_FFFF;
      end
      if (i == L - 1) begin
        data_from_memory = mem_data;
        memory_error     = mem_err;
      end else begin
        data_from_memory = 32'hBAD0_0000 | i;
        memory_error     = 1'b0;
      end
      @(posedge clk); #1;
    end
    data_from_memory = 32'h0;
    memory_error     = 1'b0;
    chk({tag, "_resp_if_done"}, {31'b0, if_done}, {31'b0, ~exp_d});
    chk({tag, "_resp_d_done"},  {31'b0, d_done},  {31'b0, exp_d});
    chk({tag, "_resp_we"},      {31'b0, write_to_memory}, 32'h0);
    if (exp_d) begin
      chk({tag, "_d_rdata"}, d_rdata, exp_rdata);
      chk({tag, "_d_err"},   {31'b0, d_err}, {31'b0, exp_err});
    end else begin
      chk({tag, "_if_rdata"}, if_rdata, exp_rdata);
      chk({tag, "_if_err"},   {31'b0, if_err}, {31'b0, exp_err});
    end
    if (drop_at_done) begin
      if_req = 1'b0;
      d_req  = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_idle_done"}, {30'b0, if_done, d_done}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_second;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    data_from_memory = '0; memory_error = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_busy", {31'b0, busy}, 32'h0);

    // 1. Fetch read
    if_req = 1'b1; if_addr = 32'h100;
    run_access("t1_fetch", 1'b0, 32'h100, 1'b0, 32'h0,
               32'hE3A0_1005, 1'b0, 32'hE3A0_1005, 1'b0, 1'b0, 1'b1);

    // 3. Tie held for three accesses (last_grant is IF here)
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_second = 1'b0;
`else
    exp_second = 1'b1;
`endif
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    run_access("t3_tie1", 1'b1, 32'h500, 1'b0, 32'h0,
               32'h0000_0A01, 1'b0, 32'h0000_0A01, 1'b0, 1'b0, 1'b0);
    run_access("t3_tie2", exp_second, exp_second ? 32'h500 : 32'h400, 1'b0, 32'h0,
               32'h0000_0A02, 1'b0, 32'h0000_0A02, 1'b0, 1'b0, 1'b0);
    run_access("t3_tie3", 1'b1, 32'h500, 1'b0, 32'h0,
               32'h0000_0A03, 1'b0, 32'h0000_0A03, 1'b0, 1'b0, 1'b1);

    // 2. Store: read data forced to zero
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    run_access("t2_store", 1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF,
               32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // 4. Load with memory error, then a clean fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
    run_access("t4_err_load", 1'b1, 32'h300, 1'b0, 32'h0,
               32'hCAFE_F00D, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    if_req = 1'b1; if_addr = 32'h104;
    run_access("t4_clean_fetch", 1'b0, 32'h104, 1'b0, 32'h0,
               32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 1'b1);
    chk("t4_d_err_hold",   {31'b0, d_err}, 32'h1);
    chk("t4_d_rdata_hold", d_rdata, 32'h0);

    // 6. Fetch request dropped mid-access
    if_req = 1'b1; if_addr = 32'h800;
    run_access("t6_drop", 1'b0, 32'h800, 1'b0, 32'h0,
               32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("t6_still_idle", {31'b0, busy}, 32'h0);
    chk("t6_no_done",    {30'b0, if_done, d_done}, 32'h0);

    // 5. Reset during a store ACCESS
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h900; d_wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    chk("t5_in_access_we", {31'b0, write_to_memory}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("t5_rst_no_done", {30'b0, if_done, d_done}, 32'h0);
      chk("t5_rst_busy",    {31'b0, busy}, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_release_idle", {31'b0, busy}, 32'h0);

    // First tie after reset goes to the data port in both build modes
    if_req = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    run_access("t5_after", 1'b1, 32'h700, 1'b0, 32'h0,
               32'h7777_0001, 1'b0, 32'h7777_0001, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
